// File: rtl/rdmap_pkg.sv
// Shared RDMAP definitions: queue index width, scheduler states, opcodes.
package rdmap_pkg;

  localparam int unsigned QN_W = 2;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_BURST = 2'd1,
    SCH_DONE  = 2'd2
  } sch_state_t;

  localparam logic [3:0] SEND_OPCODE = 4'b0000;
  localparam logic [3:0] ACK_OPCODE  = 4'b0111;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first request at or above i_ptr, wrapping.
module rr_arbiter4
  import rdmap_pkg::*;
(
  input  logic [3:0]      i_req,
  input  logic [QN_W-1:0] i_ptr,
  output logic [QN_W-1:0] o_grant,
  output logic            o_anyGrant
);

  logic [QN_W-1:0] w_idx;

  // Scan from the pointer upward; index arithmetic wraps naturally modulo 4.
  always_comb begin
    o_grant    = '0;
    o_anyGrant = 1'b0;
    w_idx      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = i_ptr + QN_W'(i);
      if (!o_anyGrant && i_req[w_idx]) begin
        o_grant    = w_idx;
        o_anyGrant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rdmap_send_scheduler.sv
// Credit-based round-robin burst scheduler for the 4-queue RDMAP send buffer.
module rdmap_send_scheduler
  import rdmap_pkg::*;
#(
  parameter int unsigned NUM_Q       = 4,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned INIT_CREDIT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [NUM_Q-1:0] emptyArray,
  input  logic             poolFull,
  input  logic             ackValid,
  input  logic [QN_W-1:0]  ackQn,
  input  logic [2:0]       ackBeats,
  output logic             dataPop,
  output logic [QN_W-1:0]  popQn,
  output logic             burstActive,
  output logic             doneValid,
  output logic [QN_W-1:0]  doneQn,
  output logic [2:0]       doneBeats,
  output logic [NUM_Q-1:0] creditZero
);

  // Sum is wide enough to hold full credit plus the largest ack without wrapping.
  localparam int unsigned          SUM_W      = CREDIT_W + 3;
  localparam logic [SUM_W-1:0]     CREDIT_MAX = {3'b000, {CREDIT_W{1'b1}}};

  sch_state_t          r_state;
  sch_state_t          w_nextState;
  logic [CREDIT_W-1:0] r_credit     [NUM_Q];
  logic [CREDIT_W-1:0] w_creditNext [NUM_Q];
  logic [SUM_W-1:0]    w_sum;
  logic [QN_W-1:0]     r_popQn;
  logic [QN_W-1:0]     r_rrPtr;
  logic [QN_W-1:0]     w_grant;
  logic                w_anyGrant;
  logic [2:0]          r_burstLen;
  logic [2:0]          r_beatCnt;
  logic [2:0]          w_grantLen;
  logic [NUM_Q-1:0]    w_req;
  logic                w_grantFire;
  logic                w_pop;

  // Eligibility: queue has data and holds at least one remote credit.
  always_comb begin
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      w_req[q]      = ~emptyArray[q] & (r_credit[q] != '0);
      creditZero[q] = (r_credit[q] == '0);
    end
  end

  rr_arbiter4 u_arb (
    .i_req      (w_req),
    .i_ptr      (r_rrPtr),
    .o_grant    (w_grant),
    .o_anyGrant (w_anyGrant)
  );

  assign w_grantFire = (r_state == SCH_IDLE) & enable & w_anyGrant;
  assign w_pop       = (r_state == SCH_BURST) & ~emptyArray[r_popQn] & ~poolFull;

  // Burst length is fixed at grant time: min(credit, MAX_BURST).
  always_comb begin
    if (r_credit[w_grant] > CREDIT_W'(MAX_BURST)) w_grantLen = 3'(MAX_BURST);
    else                                          w_grantLen = 3'(r_credit[w_grant]);
  end

  // Next-state logic: IDLE arbitrates, BURST pops, DONE reports for one cycle.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      SCH_IDLE:  if (w_grantFire) w_nextState = SCH_BURST;
      SCH_BURST: if ((w_pop && (r_beatCnt + 3'd1 == r_burstLen)) ||
                     (emptyArray[r_popQn] && (r_beatCnt != '0)))
                   w_nextState = SCH_DONE;
      SCH_DONE:  w_nextState = SCH_IDLE;
      default:   w_nextState = SCH_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= SCH_IDLE;
    else       r_state <= w_nextState;
  end

  // Burst bookkeeping: selected queue, length, beat count and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_popQn    <= '0;
      r_burstLen <= '0;
      r_beatCnt  <= '0;
      r_rrPtr    <= '0;
    end else begin
      if (w_grantFire) begin
        r_popQn    <= w_grant;
        r_burstLen <= w_grantLen;
        r_beatCnt  <= '0;
      end else if (w_pop) begin
        r_beatCnt  <= r_beatCnt + 3'd1;
      end
      if (r_state == SCH_DONE) r_rrPtr <= r_popQn + QN_W'(1);
    end
  end

  // Per-queue credit: add ack, subtract pop, saturate at the counter maximum.
  always_comb begin
    w_sum = '0;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      w_sum = {3'b000, r_credit[q]};
      if (ackValid && (ackQn == QN_W'(q))) w_sum = w_sum + SUM_W'(ackBeats);
      if (w_pop && (r_popQn == QN_W'(q)))  w_sum = w_sum - SUM_W'(1);
      w_creditNext[q] = (w_sum > CREDIT_MAX) ? '1 : w_sum[CREDIT_W-1:0];
    end
  end

  // Credit registers.
  always_ff @(posedge clock or posedge reset) begin
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      if (reset) r_credit[q] <= CREDIT_W'(INIT_CREDIT);
      else       r_credit[q] <= w_creditNext[q];
    end
  end

  assign dataPop     = w_pop;
  assign popQn       = r_popQn;
  assign burstActive = (r_state == SCH_BURST);
  assign doneValid   = (r_state == SCH_DONE);
  assign doneQn      = doneValid ? r_popQn   : '0;
  assign doneBeats   = doneValid ? r_beatCnt : '0;

endmodule

// File: tb/tb_rdmap_send_scheduler.sv
// Self-checking bench for rdmap_send_scheduler: directed scenarios plus a random phase,
// all checked against a burst-level reference model of credits and round-robin order.
module tb_rdmap_send_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] emptyArray;
  logic       poolFull;
  logic       ackValid;
  logic [1:0] ackQn;
  logic [2:0] ackBeats;
  logic       dataPop;
  logic [1:0] popQn;
  logic       burstActive;
  logic       doneValid;
  logic [1:0] doneQn;
  logic [2:0] doneBeats;
  logic [3:0] creditZero;

  int checks = 0;
  int errors = 0;

  // Reference model: per-queue credit and round-robin start point.
  int mc [4];
  int rr;

  rdmap_send_scheduler #(
    .NUM_Q       (4),
    .CREDIT_W    (4),
    .MAX_BURST   (4),
    .INIT_CREDIT (0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .emptyArray  (emptyArray),
    .poolFull    (poolFull),
    .ackValid    (ackValid),
    .ackQn       (ackQn),
    .ackBeats    (ackBeats),
    .dataPop     (dataPop),
    .popQn       (popQn),
    .burstActive (burstActive),
    .doneValid   (doneValid),
    .doneQn      (doneQn),
    .doneBeats   (doneBeats),
    .creditZero  (creditZero)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_cz();
    logic [3:0] cz;
    for (int q = 0; q < 4; q++) cz[q] = (mc[q] == 0);
    return cz;
  endfunction

  // Round-robin search over the model's view of eligibility.
  function automatic int pick(input logic [3:0] e);
    for (int i = 0; i < 4; i++) begin
      int q;
      q = (rr + i) % 4;
      if (!e[q] && mc[q] > 0) return q;
    end
    return -1;
  endfunction

  task automatic model_credit(input logic av, input logic [1:0] aq, input logic [2:0] ab,
                              input logic pop, input int pq);
    if (av) mc[aq] = mc[aq] + ab;
    if (pop) mc[pq] = mc[pq] - 1;
    for (int q = 0; q < 4; q++) if (mc[q] > 15) mc[q] = 15;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] e, input logic pf,
                       input logic av, input logic [1:0] aq, input logic [2:0] ab);
    enable = en; emptyArray = e; poolFull = pf;
    ackValid = av; ackQn = aq; ackBeats = ab;
    #3;
  endtask

  task automatic rand_ack(input bit rnd, output logic av, output logic [1:0] aq,
                          output logic [2:0] ab);
    av = 1'b0; aq = 2'd0; ab = 3'd0;
    if (rnd && ($urandom % 3 == 0)) begin
      av = 1'b1; aq = 2'($urandom % 4); ab = 3'($urandom % 8);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dataPop"}, 8'(dataPop), 8'd0);
    check({tag, "_popQn"}, 8'(popQn), 8'd0);
    check({tag, "_burstActive"}, 8'(burstActive), 8'd0);
    check({tag, "_doneValid"}, 8'(doneValid), 8'd0);
    check({tag, "_doneQn"}, 8'(doneQn), 8'd0);
    check({tag, "_doneBeats"}, 8'(doneBeats), 8'd0);
    check({tag, "_creditZero"}, 8'(creditZero), 8'h0f);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'hf, 1'b0, 1'b0, 2'd0, 3'd0);
    next_cycle();
    #2;
    check_zero_outputs("reset");
    next_cycle();
    reset = 1'b0;
    for (int q = 0; q < 4; q++) mc[q] = 0;
    rr = 0;
  endtask

  // One cycle in which no burst may start (enable low or nothing eligible).
  task automatic idle_cycle(input logic en, input logic [3:0] e,
                            input logic av, input logic [1:0] aq, input logic [2:0] ab);
    drive(en, e, 1'b0, av, aq, ab);
    check("idle_dataPop", 8'(dataPop), 8'd0);
    check("idle_burstActive", 8'(burstActive), 8'd0);
    check("idle_doneValid", 8'(doneValid), 8'd0);
    check("idle_creditZero", 8'(creditZero), 8'(model_cz()));
    model_credit(av, aq, ab, 1'b0, 0);
    next_cycle();
  endtask

  // One complete burst from IDLE arbitration through DONE, checked cycle by cycle.
  task automatic do_burst(input logic [3:0] e, input int empty_at,
                          input int stall_at, input int stall_len,
                          input int ack_idx, input logic [2:0] ack_beats, input bit rnd);
    int q, len, pops, stalled, cyc;
    bit fin;
    logic av, pf, exp_pop;
    logic [1:0] aq;
    logic [2:0] ab;
    logic [3:0] cur_e;
    q = pick(e);
    if (q < 0) begin
      check("burst_no_eligible_queue", 8'd0, 8'd1);
      return;
    end
    len = (mc[q] < 4) ? mc[q] : 4;
    // arbitration cycle
    rand_ack(rnd, av, aq, ab);
    drive(1'b1, e, 1'b0, av, aq, ab);
    check("grant_dataPop", 8'(dataPop), 8'd0);
    check("grant_burstActive", 8'(burstActive), 8'd0);
    check("grant_creditZero", 8'(creditZero), 8'(model_cz()));
    model_credit(av, aq, ab, 1'b0, 0);
    next_cycle();
    pops = 0; stalled = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 200) begin
      cur_e = e;
      if (empty_at >= 0 && pops >= empty_at) cur_e[q] = 1'b1;
      pf = 1'b0;
      if (stall_at >= 0 && pops == stall_at && stalled < stall_len) begin
        pf = 1'b1; stalled++;
      end else if (rnd) begin
        pf = ($urandom % 4 == 0);
      end
      exp_pop = !cur_e[q] && !pf;
      if (ack_idx >= 0 && pops == ack_idx && exp_pop) begin
        av = 1'b1; aq = 2'(q); ab = ack_beats;
      end else begin
        rand_ack(rnd, av, aq, ab);
      end
      drive(1'b1, cur_e, pf, av, aq, ab);
      check("burst_burstActive", 8'(burstActive), 8'd1);
      check("burst_popQn", 8'(popQn), 8'(q));
      check("burst_dataPop", 8'(dataPop), 8'(exp_pop));
      check("burst_doneValid", 8'(doneValid), 8'd0);
      check("burst_creditZero", 8'(creditZero), 8'(model_cz()));
      model_credit(av, aq, ab, exp_pop, q);
      next_cycle();
      if (exp_pop) pops++;
      if (exp_pop && pops == len) fin = 1;
      else if (cur_e[q] && pops >= 1) fin = 1;
      cyc++;
    end
    if (!fin) check("burst_cycle_budget", 8'd0, 8'd1);
    // completion cycle
    rand_ack(rnd, av, aq, ab);
    drive(1'b1, e, 1'b0, av, aq, ab);
    check("done_doneValid", 8'(doneValid), 8'd1);
    check("done_doneQn", 8'(doneQn), 8'(q));
    check("done_doneBeats", 8'(doneBeats), 8'(pops));
    check("done_dataPop", 8'(dataPop), 8'd0);
    check("done_burstActive", 8'(burstActive), 8'd0);
    check("done_creditZero", 8'(creditZero), 8'(model_cz()));
    model_credit(av, aq, ab, 1'b0, 0);
    next_cycle();
    rr = (q + 1) % 4;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0; emptyArray = 4'hf; poolFull = 1'b0;
    ackValid = 1'b0; ackQn = 2'd0; ackBeats = 3'd0;

    do_reset();

    // Basic burst: 3 credits on q1, only q1 has data.
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd1, 3'd3);
    do_burst(4'b1101, -1, -1, 0, -1, 3'd0, 1'b0);
    idle_cycle(1'b1, 4'b1101, 1'b0, 2'd0, 3'd0);

    // Round-robin: 7 credits on q0 and q2, both always have data.
    do_reset();
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd0, 3'd7);
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd2, 3'd7);
    for (int i = 0; i < 4; i++) do_burst(4'b1010, -1, -1, 0, -1, 3'd0, 1'b0);
    idle_cycle(1'b1, 4'b1010, 1'b0, 2'd0, 3'd0);

    // Early empty: q3 runs dry after 2 pops, then the remaining 2 credits are used.
    do_reset();
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd3, 3'd4);
    do_burst(4'b0111, 2, -1, 0, -1, 3'd0, 1'b0);
    do_burst(4'b0111, -1, -1, 0, -1, 3'd0, 1'b0);

    // Backpressure: poolFull for 5 cycles after the second pop.
    do_reset();
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd1, 3'd6);
    do_burst(4'b1101, -1, 2, 5, -1, 3'd0, 1'b0);

    // Saturation and simultaneous ack+pop on q0.
    do_reset();
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd0, 3'd7);
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd0, 3'd7);
    do_burst(4'b1110, -1, -1, 0, 0, 3'd7, 1'b0);
    do_burst(4'b1110, -1, -1, 0, -1, 3'd0, 1'b0);
    do_burst(4'b1110, -1, -1, 0, -1, 3'd0, 1'b0);
    do_burst(4'b1110, -1, -1, 0, 2, 3'd1, 1'b0);
    do_burst(4'b1110, -1, -1, 0, -1, 3'd0, 1'b0);
    idle_cycle(1'b1, 4'b1110, 1'b0, 2'd0, 3'd0);

    // Reset mid-burst: outputs clear at once, credits drop, no completion reported.
    do_reset();
    idle_cycle(1'b0, 4'hf, 1'b1, 2'd2, 3'd5);
    drive(1'b1, 4'b1011, 1'b0, 1'b0, 2'd0, 3'd0);
    next_cycle();
    drive(1'b1, 4'b1011, 1'b0, 1'b0, 2'd0, 3'd0);
    check("midrst_first_pop", 8'(dataPop), 8'd1);
    check("midrst_popQn", 8'(popQn), 8'd2);
    next_cycle();
    drive(1'b1, 4'b1011, 1'b0, 1'b0, 2'd0, 3'd0);
    check("midrst_burstActive_before", 8'(burstActive), 8'd1);
    reset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    next_cycle();
    reset = 1'b0;
    for (int q = 0; q < 4; q++) mc[q] = 0;
    rr = 0;
    idle_cycle(1'b0, 4'b1011, 1'b1, 2'd2, 3'd3);
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 4'b1011, 1'b0, 2'd0, 3'd0);

    // Random phase.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      logic [3:0] e;
      logic av;
      logic [1:0] aq;
      logic [2:0] ab;
      e = 4'($urandom);
      if (pick(e) >= 0 && ($urandom % 4 != 0)) begin
        int ea;
        ea = ($urandom % 2 == 0) ? -1 : int'($urandom_range(1, 3));
        do_burst(e, ea, -1, 0, -1, 3'd0, 1'b1);
      end else begin
        rand_ack(1'b1, av, aq, ab);
        if ($urandom % 2 == 0) begin
          av = 1'b1; aq = 2'($urandom % 4); ab = 3'($urandom_range(1, 7));
        end
        idle_cycle((pick(e) < 0) ? 1'b1 : 1'b0, e, av, aq, ab);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
